// File: rtl/sar_search_4bit.sv
// sar_search_4bit
// Successive-approximation search over a compare-only path. The block drives a
// trial value onto the B input of an external magnitude comparator, waits for
// the comparator to settle, samples its gt/eq/lt flags and narrows the search
// one bit per trial until the hidden A operand is recovered.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    request a new search (accepted only while idle)
//   guess    trial value to the comparator B input
//   cmp_gt   comparator A > B
//   cmp_eq   comparator A == B
//   cmp_lt   comparator A < B
//   busy     search in progress
//   done     one-cycle pulse, result/error valid
//   result   recovered value, held until the next accepted start
//   error    flags were not one-hot when sampled, held until the next start
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; guess/result/error hold their last values
// S_TRIAL | guess held stable, settle counter running, flags sampled at
//         | terminal count
// S_DONE  | one-cycle done pulse, then back to S_IDLE

module sar_search_4bit #(
    parameter int WIDTH       = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(WAIT_CYCLES);
    localparam logic [WIDTH-1:0] GUESS_TOP = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRIAL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [BIT_W-1:0] bit_idx, bit_idx_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] guess_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             error_nxt;
    logic [WIDTH-1:0] acc_upd;
    logic             flags_onehot;

    // Exactly one of three bits set: odd parity rules out 0 and 2 set,
    // and the AND term rules out all three.
    assign flags_onehot = (cmp_gt ^ cmp_eq ^ cmp_lt) & ~(cmp_gt & cmp_eq & cmp_lt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_idx <= '0;
            acc     <= '0;
            guess   <= '0;
            cnt     <= '0;
            result  <= '0;
            error   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
            acc     <= acc_nxt;
            guess   <= guess_nxt;
            cnt     <= cnt_nxt;
            result  <= result_nxt;
            error   <= error_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        acc_nxt     = acc;
        guess_nxt   = guess;
        cnt_nxt     = cnt;
        result_nxt  = result;
        error_nxt   = error;
        // A gt answer means the trial bit belongs in the target; since guess
        // is acc with the trial bit set, keeping it is just taking guess.
        acc_upd     = cmp_gt ? guess : acc;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    bit_idx_nxt = BIT_TOP;
                    acc_nxt     = '0;
                    guess_nxt   = GUESS_TOP;
                    cnt_nxt     = '0;
                    result_nxt  = '0;
                    error_nxt   = 1'b0;
                    state_nxt   = S_TRIAL;
                end
            end

            S_TRIAL: begin
                busy = 1'b1;
                if (cnt == CNT_TC) begin
                    if (!flags_onehot) begin
                        error_nxt  = 1'b1;
                        result_nxt = '0;
                        state_nxt  = S_DONE;
                    end else if (cmp_eq) begin
                        result_nxt = guess;
                        state_nxt  = S_DONE;
                    end else begin
                        acc_nxt = acc_upd;
                        if (bit_idx == '0) begin
                            result_nxt = acc_upd;
                            state_nxt  = S_DONE;
                        end else begin
                            bit_idx_nxt = bit_idx - 1'b1;
                            guess_nxt   = acc_upd | (WIDTH'(1) << (bit_idx - 1'b1));
                            cnt_nxt     = '0;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search_4bit.sv
// Testbench for sar_search_4bit. Two instances: one with the default settle
// time, one with WAIT_CYCLES=3 and start held high across back-to-back searches.
// Expected values come from closed-form properties of a binary search: the
// result is the target, the trial count is set by the lowest set bit of the
// target, and trial m's guess is the target's upper bits with a 1 appended.

module tb_sar_search_4bit;

    localparam int W  = 4;
    localparam int WA = 1;
    localparam int WB = 3;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    logic         start_a, start_b;
    logic [W-1:0] guess_a, guess_b;
    logic [W-1:0] result_a, result_b;
    logic         busy_a, busy_b, done_a, done_b, error_a, error_b;
    logic [W-1:0] target_a, target_b;
    logic         bad_a;

    logic gt_a, eq_a, lt_a, gt_b, eq_b, lt_b;

    // External comparator; bad_a forces gt and lt together.
    assign gt_a = bad_a ? 1'b1 : (target_a > guess_a);
    assign eq_a = bad_a ? 1'b0 : (target_a == guess_a);
    assign lt_a = bad_a ? 1'b1 : (target_a < guess_a);
    assign gt_b = target_b > guess_b;
    assign eq_b = target_b == guess_b;
    assign lt_b = target_b < guess_b;

    sar_search_4bit #(.WIDTH(W), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .guess(guess_a),
        .cmp_gt(gt_a), .cmp_eq(eq_a), .cmp_lt(lt_a),
        .busy(busy_a), .done(done_a), .result(result_a), .error(error_a)
    );

    sar_search_4bit #(.WIDTH(W), .WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .guess(guess_b),
        .cmp_gt(gt_b), .cmp_eq(eq_b), .cmp_lt(lt_b),
        .busy(busy_b), .done(done_b), .result(result_b), .error(error_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Number of trials until the search ends: it stops on eq when the trial
    // bit reaches the target's lowest set bit; a zero target runs all trials.
    function automatic int trials(input int t);
        for (int b = 0; b < W; b++)
            if (t[b]) return W - b;
        return W;
    endfunction

    // Guess on trial m: target bits above the trial position, trial bit set.
    function automatic int exp_guess(input int t, input int m);
        int p;
        p = W - m;
        return ((t >> (p + 1)) << (p + 1)) | (1 << p);
    endfunction

    // One search on instance A. bad_trial>0 forces illegal flags on that trial.
    task automatic search_a(input int tgt, input int bad_trial);
        int k, exp_n, done_cnt, done_j, exp_res, exp_err, per;
        per      = WA + 1;
        target_a = W'(tgt);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        k        = cyc;
        exp_n    = (bad_trial > 0) ? bad_trial : trials(tgt);
        exp_res  = (bad_trial > 0) ? 0 : tgt;
        exp_err  = (bad_trial > 0) ? 1 : 0;
        done_cnt = 0;
        done_j   = -1;
        check("a_clr_res", int'(result_a), 0);
        check("a_clr_err", int'(error_a), 0);
        check("a_busy", int'(busy_a), 1);
        for (int j = 0; j <= W * per + 4; j++) begin
            if (j > 0) @(negedge clk);
            bad_a = (bad_trial > 0) && (j >= (bad_trial - 1) * per) && (j < bad_trial * per);
            for (int m = 1; m <= exp_n; m++)
                if (j == (m - 1) * per)
                    check($sformatf("a_guess_t%0d_m%0d", tgt, m), int'(guess_a), exp_guess(tgt, m));
            if (done_a) begin
                done_cnt++;
                if (done_j < 0) done_j = j;
            end
        end
        bad_a = 1'b0;
        check($sformatf("a_lat_t%0d", tgt), done_j, exp_n * per);
        check("a_pulses", done_cnt, 1);
        check($sformatf("a_res_t%0d", tgt), int'(result_a), exp_res);
        check("a_err", int'(error_a), exp_err);
        check("a_idle_busy", int'(busy_a), 0);
        if (k < 0) check("a_k", k, 0);
    endtask

    function automatic int b_target(input int i);
        return (i == 0) ? 3 : i - 1;
    endfunction

    initial begin
        int k, t, got, dcnt;
        cyc      = 0;
        n_tests  = 0;
        n_fail   = 0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        bad_a    = 1'b0;
        target_a = '0;
        target_b = '0;
        rst      = 1'b1;
        #1;
        check("rst_guess", int'(guess_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_result", int'(result_a), 0);
        check("rst_error", int'(error_a), 0);
        check("rst_b_busy", int'(busy_b), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        // Directed targets, then an illegal-flag search, then recovery.
        search_a(5, 0);
        search_a(8, 0);
        search_a(0, 0);
        search_a(15, 0);
        search_a(5, 2);
        search_a(6, 0);

        // Abort mid-search with reset.
        target_a = 4'd5;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_guess", int'(guess_a), 0);
        check("abort_busy", int'(busy_a), 0);
        check("abort_done", int'(done_a), 0);
        check("abort_result", int'(result_a), 0);
        check("abort_error", int'(error_a), 0);
        @(negedge clk) rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_a) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        search_a(10, 0);

        // Randomized targets.
        for (int i = 0; i < 10; i++)
            search_a(int'($urandom_range(0, 15)), 0);

        // Instance B: start held high, back-to-back searches over all targets.
        target_b = W'(b_target(0));
        @(negedge clk) start_b = 1'b1;
        @(negedge clk);
        k = cyc;
        for (int i = 0; i < 17; i++) begin
            t   = b_target(i);
            got = 0;
            for (int w = 0; w < 40 && got == 0; w++) begin
                if (done_b) got = 1;
                else @(negedge clk);
            end
            check($sformatf("b_lat_t%0d", t), cyc - k, trials(t) * (WB + 1));
            check($sformatf("b_res_t%0d", t), int'(result_b), t);
            check("b_err", int'(error_b), 0);
            target_b = W'(b_target(i + 1));
            @(negedge clk);
            check("b_idle_busy", int'(busy_b), 0);
            check("b_idle_done", int'(done_b), 0);
            @(negedge clk);
            check("b_accept_busy", int'(busy_b), 1);
            check("b_accept_guess", int'(guess_b), 8);
            k = cyc;
        end
        start_b = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
